cpack_dict_ctrl: RTL and testbench

- Sequences the compressor's word-level datapath.
- Owns the 16-entry FIFO-replacement dictionary and presents each input word plus the dictionary to the external comparator bank (zero/zzzx, full, mmmx, mmxx matchers).
- Selects the shortest code from the returned match flags, emits one code record per word over a valid/ready handshake, then updates the dictionary.
- Sits between the input word stream and the bit packer.

---
 rtl/cpack_dict_ctrl.sv | 144 ++++++++++++++
 tb/tb_cpack_dict_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpack_dict_ctrl.sv
// Word-level sequencer for the compressor: owns the FIFO-replacement
// dictionary, presents each word to the external comparator bank, picks the
// shortest code from the returned flags and hands one record per word to the
// bit packer.
module cpack_dict_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned WORDS = 16,
    parameter int unsigned IDXW  = $clog2(WORDS)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [WIDTH-1:0]       in_word_i,
    input  logic                   flush_i,
    output logic [WIDTH-1:0]       cmp_word_o,
    output logic [WORDS*WIDTH-1:0] dictionary_o,
    output logic [WORDS-1:0]       entry_valid_o,
    input  logic                   match_zero_i,
    input  logic                   match_full_i,
    input  logic                   match_zzzx_i,
    input  logic                   match_mmmx_i,
    input  logic                   match_mmxx_i,
    input  logic [IDXW-1:0]        match_idx_i,
    input  logic [7:0]             zzzx_byte_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [33:0]            out_code_o,
    output logic [5:0]             out_len_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StEval = 2'd1;
    localparam logic [1:0] StEmit = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_cmp_word;
    logic [WIDTH-1:0] r_dict [WORDS];
    logic [WORDS-1:0] r_valid;
    logic [IDXW-1:0]  r_wr_ptr;
    logic             r_out_valid;
    logic [33:0]      r_out_code;
    logic [5:0]       r_out_len;

    logic [33:0]      w_code;
    logic [5:0]       w_len;
    logic             w_push;

    assign in_ready_o    = (r_state == StIdle) | ((r_state == StEmit) & out_ready_i);
    assign cmp_word_o    = r_cmp_word;
    assign entry_valid_o = r_valid;
    assign out_valid_o   = r_out_valid;
    assign out_code_o    = r_out_code;
    assign out_len_o     = r_out_len;

    for (genvar k = 0; k < WORDS; k++) begin : g_dict_out
        assign dictionary_o[k*WIDTH +: WIDTH] = r_dict[k];
    end

    // Priority code selection; only codes that carry raw word bits get pushed.
    always_comb begin
        w_code = '0;
        w_len  = 6'd34;
        w_push = 1'b0;
        if (match_zero_i) begin
            w_len = 6'd2;
        end else if (match_full_i) begin
            w_code[IDXW+1:0] = {2'b10, match_idx_i};
            w_len            = 6'd6;
        end else if (match_zzzx_i) begin
            w_code[11:0] = {4'b1101, zzzx_byte_i};
            w_len        = 6'd12;
        end else if (match_mmmx_i) begin
            w_code[IDXW+11:0] = {4'b1110, match_idx_i, r_cmp_word[7:0]};
            w_len             = 6'd16;
            w_push            = 1'b1;
        end else if (match_mmxx_i) begin
            w_code[IDXW+19:0] = {4'b1100, match_idx_i, r_cmp_word[15:0]};
            w_len             = 6'd24;
            w_push            = 1'b1;
        end else begin
            w_code[WIDTH+1:0] = {2'b01, r_cmp_word};
            w_push            = 1'b1;
        end
    end

    // Handshake FSM: latch word, evaluate for one cycle, hold record until taken.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= StIdle;
            r_cmp_word  <= '0;
            r_out_valid <= 1'b0;
            r_out_code  <= '0;
            r_out_len   <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (in_valid_i) begin
                        r_cmp_word <= in_word_i;
                        r_state    <= StEval;
                    end
                end
                StEval: begin
                    r_out_code  <= w_code;
                    r_out_len   <= w_len;
                    r_out_valid <= 1'b1;
                    r_state     <= StEmit;
                end
                StEmit: begin
                    if (out_ready_i) begin
                        r_out_valid <= 1'b0;
                        if (in_valid_i) begin
                            r_cmp_word <= in_word_i;
                            r_state    <= StEval;
                        end else begin
                            r_state <= StIdle;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Dictionary update; a flush wins over a push in the same cycle and
    // leaves stale data behind the cleared valid bits.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int k = 0; k < WORDS; k++) begin
                r_dict[k] <= '0;
            end
            r_valid  <= '0;
            r_wr_ptr <= '0;
        end else if (flush_i) begin
            r_valid  <= '0;
            r_wr_ptr <= '0;
        end else if ((r_state == StEval) && w_push) begin
            r_dict[r_wr_ptr]  <= r_cmp_word;
            r_valid[r_wr_ptr] <= 1'b1;
            r_wr_ptr          <= r_wr_ptr + 1'b1;
        end
    end

endmodule

// File: tb/tb_cpack_dict_ctrl.sv
// Self-checking bench for cpack_dict_ctrl: directed scenarios followed by
// randomized words/flags, checked against a dictionary model.
module tb_cpack_dict_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_word;
    logic         flush;
    logic [31:0]  cmp_word;
    logic [511:0] dict;
    logic [15:0]  entry_valid;
    logic         mz, mf, mzz, mm3, mm2;
    logic [3:0]   midx;
    logic [7:0]   zb;
    logic         out_valid;
    logic         out_ready;
    logic [33:0]  out_code;
    logic [5:0]   out_len;

    cpack_dict_ctrl dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_word_i    (in_word),
        .flush_i      (flush),
        .cmp_word_o   (cmp_word),
        .dictionary_o (dict),
        .entry_valid_o(entry_valid),
        .match_zero_i (mz),
        .match_full_i (mf),
        .match_zzzx_i (mzz),
        .match_mmmx_i (mm3),
        .match_mmxx_i (mm2),
        .match_idx_i  (midx),
        .zzzx_byte_i  (zb),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_code_o   (out_code),
        .out_len_o    (out_len)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_dict [16];
    logic [15:0] m_valid;
    int          m_ptr;
    logic [31:0] m_cur;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] m_flat();
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[k*32 +: 32] = m_dict[k];
        return r;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 16; k++) m_dict[k] = '0;
        m_valid = '0;
        m_ptr   = 0;
        m_cur   = '0;
    endtask

    // f = {zero, full, zzzx, mmmx, mmxx}
    task automatic expect_code(input logic [4:0] f, input logic [3:0] idx, input logic [7:0] b,
                               input logic [31:0] w, output logic [33:0] c,
                               output logic [5:0] l, output bit push);
        push = 1'b0;
        if (f[4]) begin
            c = 34'd0; l = 6'd2;
        end else if (f[3]) begin
            c = 34'd32 + 34'(idx); l = 6'd6;
        end else if (f[2]) begin
            c = 34'd13 * 34'd256 + 34'(b); l = 6'd12;
        end else if (f[1]) begin
            c = 34'd14 * 34'd4096 + 34'(idx) * 34'd256 + 34'(w % 256); l = 6'd16; push = 1'b1;
        end else if (f[0]) begin
            c = 34'd12 * 34'd1048576 + 34'(idx) * 34'd65536 + 34'(w % 65536);
            l = 6'd24; push = 1'b1;
        end else begin
            c = 34'h1_0000_0000 + 34'(w); l = 6'd34; push = 1'b1;
        end
    endtask

    task automatic junk_flags();
        {mz, mf, mzz, mm3, mm2} = 5'($urandom);
        midx = 4'($urandom);
        zb   = 8'($urandom);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge inside EVAL.
    task automatic accept(input logic [31:0] w, input bit fl);
        in_valid = 1'b1;
        in_word  = w;
        flush    = fl;
        junk_flags();
        #1 chk("in_ready_idle", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        if (fl) begin m_valid = '0; m_ptr = 0; end
        m_cur = w;
        chk("cmp_word", cmp_word, w);
        chk("out_valid_in_eval", out_valid, 0);
        chk("in_ready_in_eval", in_ready, 0);
    endtask

    // Runs the EVAL cycle and EMIT phase; optionally chains the next word.
    task automatic eval_emit(input logic [4:0] f, input logic [3:0] idx, input logic [7:0] b,
                             input bit fl, input int hold, input bit chain,
                             input logic [31:0] nw);
        logic [33:0] ec;
        logic [5:0]  el;
        bit          push;
        {mz, mf, mzz, mm3, mm2} = f;
        midx  = idx;
        zb    = b;
        flush = fl;
        expect_code(f, idx, b, m_cur, ec, el, push);
        @(negedge clk);
        flush = 1'b0;
        junk_flags();
        if (fl) begin
            m_valid = '0; m_ptr = 0;
        end else if (push) begin
            m_dict[m_ptr]  = m_cur;
            m_valid[m_ptr] = 1'b1;
            m_ptr          = (m_ptr + 1) % 16;
        end
        chk("out_valid", out_valid, 1);
        chk("out_code", out_code, ec);
        chk("out_len", out_len, el);
        chk("entry_valid", entry_valid, m_valid);
        chk("dictionary", dict, m_flat());
        chk("in_ready_emit_stall", in_ready, 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            junk_flags();
            chk("hold_valid", out_valid, 1);
            chk("hold_code", out_code, ec);
            chk("hold_len", out_len, el);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        if (chain) begin
            in_valid = 1'b1;
            in_word  = nw;
        end
        #1 chk("in_ready_release", in_ready, 1);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("out_valid_drop", out_valid, 0);
        if (chain) begin
            m_cur = nw;
            chk("chain_cmp_word", cmp_word, nw);
            chk("chain_in_ready", in_ready, 0);
        end else begin
            chk("back_to_idle", in_ready, 1);
        end
    endtask

    initial begin
        bit          pend;
        bit          ch;
        logic [31:0] nw;

        rst_n = 1'b0; in_valid = 1'b0; in_word = '0; flush = 1'b0; out_ready = 1'b0;
        {mz, mf, mzz, mm3, mm2} = '0; midx = '0; zb = '0;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_entry_valid", entry_valid, 0);
        chk("rst_dict", dict, 0);
        chk("rst_cmp_word", cmp_word, 0);
        chk("rst_code", out_code, 0);
        chk("rst_len", out_len, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        // Zero word
        accept(32'h0, 1'b0);
        eval_emit(5'b10000, 4'd0, 8'd0, 1'b0, 0, 1'b0, 32'h0);
        chk("zero_no_push", entry_valid, 16'h0000);

        // Raw word into empty dictionary, then a full match on it
        accept(32'h1234_5678, 1'b0);
        eval_emit(5'b00000, 4'd0, 8'd0, 1'b0, 0, 1'b0, 32'h0);
        chk("xxxx_entry0", dict[31:0], 32'h1234_5678);
        chk("xxxx_valid", entry_valid, 16'h0001);
        accept(32'h1234_5678, 1'b0);
        eval_emit(5'b01000, 4'd0, 8'd0, 1'b0, 0, 1'b0, 32'h0);
        chk("full_code", out_code, 34'h20);
        chk("full_no_push", entry_valid, 16'h0001);

        // 17 raw words; flush with the first acceptance clears the dictionary
        for (int i = 1; i <= 17; i++) begin
            accept(32'h1000_0000 + 32'(i), i == 1);
            eval_emit(5'b00000, 4'd0, 8'd0, 1'b0, 0, 1'b0, 32'h0);
            if (i == 16) chk("fill_all_valid", entry_valid, 16'hFFFF);
        end
        chk("wrap_entry0", dict[31:0], 32'h1000_0011);

        // mmmx held by backpressure, released with next word chained; that
        // word is flushed during EVAL
        accept(32'hAABB_CC7E, 1'b0);
        eval_emit(5'b00010, 4'd3, 8'd0, 1'b0, 5, 1'b1, 32'hCAFE_F00D);
        chk("mmmx_push_slot1", dict[63:32], 32'hAABB_CC7E);
        eval_emit(5'b00000, 4'd0, 8'd0, 1'b1, 0, 1'b0, 32'h0);
        chk("flush_eval_valid", entry_valid, 16'h0000);

        // Wrap pointer restarted: next push lands in entry 0
        accept(32'h0BAD_BEEF, 1'b0);
        eval_emit(5'b00001, 4'd7, 8'd0, 1'b0, 0, 1'b0, 32'h0);
        chk("after_flush_slot0", dict[31:0], 32'h0BAD_BEEF);

        // Reset while a record is pending
        accept(32'h0000_0055, 1'b0);
        {mz, mf, mzz, mm3, mm2} = 5'b00100;
        @(negedge clk);
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("emit_rst_valid", out_valid, 0);
        chk("emit_rst_code", out_code, 0);
        chk("emit_rst_entries", entry_valid, 0);
        rst_n = 1'b1;
        m_reset();
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);

        // Randomized traffic
        pend = 1'b0;
        for (int i = 0; i < 80; i++) begin
            logic [4:0] f;
            for (int k = 0; k < 5; k++) f[k] = ($urandom_range(0, 3) == 0);
            if (!pend) accept($urandom, $urandom_range(0, 7) == 0);
            nw = $urandom;
            ch = 1'($urandom_range(0, 1));
            eval_emit(f, 4'($urandom), 8'($urandom), $urandom_range(0, 7) == 0,
                      int'($urandom_range(0, 2)), ch, nw);
            pend = ch;
        end
        if (pend) eval_emit(5'b00000, 4'd0, 8'd0, 1'b0, 0, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
